burst_sequencer: RTL and testbench
==================================

# burst_sequencer

Drives the address counter's command inputs to produce bounded address bursts. It accepts a burst request (start address, length) over a valid/ready handshake and issues LOAD once, then issues INC once per beat accepted by the downstream consumer. It reports a beat handshake aligned with the counter's `addr` output and pulses `done` when the burst completes. It sits directly upstream of the address counter and shares its clock.

## Interface
- `ADDR_W`, default 11: address width; must match the counter's `addr`/`load_addr` width.
- `LEN_W`, default 8: burst length field width.

- `clk`  in  1: clock; all state updates on the rising edge.
- `reset`  in  1: synchronous, active-low reset (0 at a rising edge resets).
- `req_valid`  in  1: burst request present.
- `req_ready`  out  1: sequencer can accept a request.
- `req_addr`  in  ADDR_W: first beat address.
- `req_len`  in  LEN_W: beats minus one (0 means 1 beat, max 2^LEN_W beats).
- `cmd`  out  counter_types::cmd_t: command to the counter (NONE/INC/LOAD only).
- `load_addr`  out  ADDR_W: registered load value to the counter.
- `beat_valid`  out  1: counter `addr` currently holds an unconsumed beat address.
- `beat_ready`  in  1: downstream consumes the current beat.
- `done`  out  1: one-cycle pulse after the last beat is consumed.

## Operation
- The counter's active-high reset input is driven from `~reset` at integration, so both blocks reset in the same cycle.
- States: IDLE, LOAD, STREAM. Internal registers: `state`, `remaining[LEN_W-1:0]`, `load_addr`, `done`.
- IDLE: `req_ready=1`, `cmd=NONE`, `beat_valid=0`. When `req_valid` is 1: capture `load_addr<=req_addr` and `remaining<=req_len`, then go to LOAD.
- LOAD: `cmd=LOAD`, `req_ready=0`, `beat_valid=0`. Go to STREAM unconditionally.
- STREAM: `beat_valid=1`, `req_ready=0`.
  - `beat_ready=1` and `remaining!=0`: `cmd=INC`, `remaining<=remaining-1`.
  - `beat_ready=1` and `remaining==0`: `cmd=NONE`, go to IDLE, `done<=1`.
  - `beat_ready=0`: `cmd=NONE`. The beat is held and `beat_valid` stays 1.
- `cmd` is combinational from `state` and `beat_ready`. Every other output is a pure function of registered state.
- `done` is registered. It is high for exactly the first IDLE cycle after a completed burst and is cleared on the following cycle.
- Wrap-around: no boundary checks. A burst crossing 2^ADDR_W-1 wraps to 0 through the counter's natural overflow.
- A request arriving outside IDLE is not accepted; `req_valid` must be held until `req_ready`.
- Reset: `state=IDLE`, `remaining=0`, `load_addr=0`, `done=0`. This gives `cmd=NONE`, `req_ready=1` and `beat_valid=0` in the first cycle after reset. Reset mid-burst abandons the burst with no `done` pulse.

## Timing
- Request accepted at edge T: LOAD during cycle T+1, counter `addr=req_addr` and `beat_valid=1` in cycle T+2.
- With `beat_ready` held at 1: beats occupy cycles T+2 to T+1+N (N = req_len+1), with address A+k in cycle T+2+k.
- `done=1` and `req_ready=1` in cycle T+2+N. The next request can be accepted in that same cycle.
- Overhead is 2 cycles per burst. Each stall cycle adds 1 cycle.
- Combinational path: `beat_ready` to `cmd` only.

## Configuration
- `BURST_SEQ_ABORT_EN` defined: adds input `abort` (1 bit) and output `aborted` (1 bit, registered pulse).
  - `abort=1` in LOAD or STREAM forces `cmd=NONE` that cycle and returns to IDLE at the next edge.
  - The next cycle then has `aborted=1`, `done=0`, `remaining=0`.
  - `abort` in IDLE is ignored. If `abort` and the final beat's `beat_ready` coincide, the abort wins.
- `BURST_SEQ_ABORT_EN` undefined: neither port exists and behaviour is exactly as in Operation.

## Test plan
- Reset, then `req_addr=0x010`, `req_len=3`, `beat_ready=1`: counter `addr` shows 0x010, 0x011, 0x012, 0x013 on 4 consecutive `beat_valid` cycles, then `done=1` for one cycle.
- `req_addr=0x7FE`, `req_len=3`: addresses 0x7FE, 0x7FF, 0x000, 0x001 (wrap).
- `req_len=0`, `beat_ready` low for 3 cycles, then high: `beat_valid` is held 4 cycles at the same address, `cmd=NONE` during the stall, `done` pulses after acceptance.
- Back-to-back: a second request held valid during a burst is accepted in the `done` cycle, and its LOAD follows in the next cycle.
- `reset=0` asserted mid-STREAM: the next cycle shows IDLE, `cmd=NONE`, `beat_valid=0`, `done=0`, counter `addr=0`.
- With `BURST_SEQ_ABORT_EN`: `abort` on beat 2 of 8 → `aborted=1` next cycle, `done` never asserted, `req_ready=1`.

Source files
------------

// File: rtl/counter_types.sv
// Command encoding shared by the address counter and its upstream sequencer.
package counter_types;

  typedef enum logic [1:0] {
    CmdNone = 2'd0,
    CmdInc  = 2'd1,
    CmdDec  = 2'd2,
    CmdLoad = 2'd3
  } cmd_t;

endpackage

// File: rtl/burst_sequencer.sv
// Turns (start address, length) requests into LOAD/INC commands for the address counter.
// Optional abort port pair is compiled in when BURST_SEQ_ABORT_EN is defined.
module burst_sequencer #(
  parameter int unsigned ADDR_W = 11,
  parameter int unsigned LEN_W  = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [LEN_W-1:0]    req_len,
  output counter_types::cmd_t cmd,
  output logic [ADDR_W-1:0]   load_addr,
  output logic                beat_valid,
  input  logic                beat_ready,
`ifdef BURST_SEQ_ABORT_EN
  input  logic                abort,
  output logic                aborted,
`endif
  output logic                done
);

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StLoad   = 2'd1,
    StStream = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [LEN_W-1:0]    remaining_q, remaining_d;
  logic [ADDR_W-1:0]   load_addr_q, load_addr_d;
  logic                done_q, done_d;
  logic                abort_hit;

`ifdef BURST_SEQ_ABORT_EN
  logic aborted_q;

  // Abort is only meaningful while a burst is in flight.
  assign abort_hit = abort && (state_q != StIdle);
  assign aborted   = aborted_q;
`else
  assign abort_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= StIdle;
      remaining_q <= '0;
      load_addr_q <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      load_addr_q <= load_addr_d;
      done_q      <= done_d;
    end
  end

`ifdef BURST_SEQ_ABORT_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      aborted_q <= 1'b0;
    end else begin
      aborted_q <= abort_hit;
    end
  end
`endif

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    load_addr_d = load_addr_q;
    done_d      = 1'b0;
    cmd         = counter_types::CmdNone;

    case (state_q)
      StIdle: begin
        if (req_valid) begin
          load_addr_d = req_addr;
          remaining_d = req_len;
          state_d     = StLoad;
        end
      end
      StLoad: begin
        cmd     = counter_types::CmdLoad;
        state_d = StStream;
      end
      StStream: begin
        // A consumed beat advances the counter unless it was the last one.
        if (beat_ready) begin
          if (remaining_q != '0) begin
            cmd         = counter_types::CmdInc;
            remaining_d = remaining_q - LEN_W'(1);
          end else begin
            state_d = StIdle;
            done_d  = 1'b1;
          end
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Abort takes priority, including over the final beat's completion.
    if (abort_hit) begin
      cmd         = counter_types::CmdNone;
      state_d     = StIdle;
      remaining_d = '0;
      done_d      = 1'b0;
    end
  end

  assign req_ready  = (state_q == StIdle);
  assign beat_valid = (state_q == StStream);
  assign load_addr  = load_addr_q;
  assign done       = done_q;

endmodule

// File: tb/tb_burst_sequencer.sv
// Directed bench for burst_sequencer with a behavioural address counter alongside it.
module tb_burst_sequencer;

  localparam int unsigned ADDR_W = 11;
  localparam int unsigned LEN_W  = 8;

  logic                clk = 1'b0;
  logic                reset;
  logic                req_valid;
  logic                req_ready;
  logic [ADDR_W-1:0]   req_addr;
  logic [LEN_W-1:0]    req_len;
  counter_types::cmd_t cmd;
  logic [ADDR_W-1:0]   load_addr;
  logic                beat_valid;
  logic                beat_ready;
  logic                done;
`ifdef BURST_SEQ_ABORT_EN
  logic                abort;
  logic                aborted;
`endif

  logic [ADDR_W-1:0]   addr;
  int                  n_checks = 0;
  int                  n_errors = 0;

  always #5 clk = ~clk;

  burst_sequencer #(
    .ADDR_W (ADDR_W),
    .LEN_W  (LEN_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_len    (req_len),
    .cmd        (cmd),
    .load_addr  (load_addr),
    .beat_valid (beat_valid),
    .beat_ready (beat_ready),
`ifdef BURST_SEQ_ABORT_EN
    .abort      (abort),
    .aborted    (aborted),
`endif
    .done       (done)
  );

  // Address counter model; its reset is driven from ~reset as at integration.
  always @(posedge clk) begin
    if (!reset) addr <= '0;
    else begin
      case (cmd)
        counter_types::CmdLoad: addr <= load_addr;
        counter_types::CmdInc:  addr <= addr + 11'd1;
        default: ;
      endcase
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b0; req_valid = 1'b0; req_addr = '0; req_len = '0; beat_ready = 1'b0;
`ifdef BURST_SEQ_ABORT_EN
    abort = 1'b0;
`endif
    tick; tick; #1;
    n_checks++; if (req_ready !== 1'b1) begin n_errors++; $display("FAIL reset_req_ready: got %b expected 1", req_ready); end
    n_checks++; if (cmd !== counter_types::CmdNone) begin n_errors++; $display("FAIL reset_cmd: got %0d expected %0d", cmd, counter_types::CmdNone); end
    n_checks++; if (beat_valid !== 1'b0) begin n_errors++; $display("FAIL reset_beat_valid: got %b expected 0", beat_valid); end
    n_checks++; if (done !== 1'b0) begin n_errors++; $display("FAIL reset_done: got %b expected 0", done); end
    n_checks++; if (load_addr !== 11'h000) begin n_errors++; $display("FAIL reset_load_addr: got %h expected 000", load_addr); end
    reset = 1'b1;
  endtask

  task automatic test_basic;
    logic [ADDR_W-1:0] exp_addr [4] = '{11'h010, 11'h011, 11'h012, 11'h013};
    counter_types::cmd_t exp_cmd;
    req_valid = 1'b1; req_addr = 11'h010; req_len = 8'd3; beat_ready = 1'b1; #1;
    n_checks++; if (req_ready !== 1'b1) begin n_errors++; $display("FAIL basic_req_ready_idle: got %b expected 1", req_ready); end
    tick; req_valid = 1'b0; #1;
    n_checks++; if (cmd !== counter_types::CmdLoad) begin n_errors++; $display("FAIL basic_load_cmd: got %0d expected %0d", cmd, counter_types::CmdLoad); end
    n_checks++; if (load_addr !== 11'h010) begin n_errors++; $display("FAIL basic_load_addr: got %h expected 010", load_addr); end
    n_checks++; if (req_ready !== 1'b0 || beat_valid !== 1'b0) begin n_errors++; $display("FAIL basic_load_flags: got ready=%b valid=%b expected 0 0", req_ready, beat_valid); end
    for (int k = 0; k < 4; k++) begin
      tick; #1;
      exp_cmd = (k < 3) ? counter_types::CmdInc : counter_types::CmdNone;
      n_checks++; if (beat_valid !== 1'b1) begin n_errors++; $display("FAIL basic_beat_valid[%0d]: got %b expected 1", k, beat_valid); end
      n_checks++; if (addr !== exp_addr[k]) begin n_errors++; $display("FAIL basic_addr[%0d]: got %h expected %h", k, addr, exp_addr[k]); end
      n_checks++; if (cmd !== exp_cmd) begin n_errors++; $display("FAIL basic_cmd[%0d]: got %0d expected %0d", k, cmd, exp_cmd); end
      n_checks++; if (done !== 1'b0) begin n_errors++; $display("FAIL basic_done_early[%0d]: got %b expected 0", k, done); end
    end
    tick; #1;
    n_checks++; if (done !== 1'b1) begin n_errors++; $display("FAIL basic_done: got %b expected 1", done); end
    n_checks++; if (req_ready !== 1'b1 || beat_valid !== 1'b0) begin n_errors++; $display("FAIL basic_done_flags: got ready=%b valid=%b expected 1 0", req_ready, beat_valid); end
    tick; #1;
    n_checks++; if (done !== 1'b0) begin n_errors++; $display("FAIL basic_done_clear: got %b expected 0", done); end
  endtask

  task automatic test_wrap;
    logic [ADDR_W-1:0] exp_addr [4] = '{11'h7FE, 11'h7FF, 11'h000, 11'h001};
    req_valid = 1'b1; req_addr = 11'h7FE; req_len = 8'd3; beat_ready = 1'b1;
    tick; req_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick; #1;
      n_checks++; if (beat_valid !== 1'b1 || addr !== exp_addr[k]) begin n_errors++; $display("FAIL wrap_addr[%0d]: got valid=%b addr=%h expected 1 %h", k, beat_valid, addr, exp_addr[k]); end
    end
    tick; #1;
    n_checks++; if (done !== 1'b1) begin n_errors++; $display("FAIL wrap_done: got %b expected 1", done); end
  endtask

  task automatic test_stall;
    req_valid = 1'b1; req_addr = 11'h123; req_len = 8'd0; beat_ready = 1'b0;
    tick; req_valid = 1'b0; #1;
    n_checks++; if (cmd !== counter_types::CmdLoad) begin n_errors++; $display("FAIL stall_load_cmd: got %0d expected %0d", cmd, counter_types::CmdLoad); end
    for (int k = 0; k < 4; k++) begin
      tick; beat_ready = (k == 3); #1;
      n_checks++; if (beat_valid !== 1'b1 || addr !== 11'h123) begin n_errors++; $display("FAIL stall_hold[%0d]: got valid=%b addr=%h expected 1 123", k, beat_valid, addr); end
      n_checks++; if (cmd !== counter_types::CmdNone) begin n_errors++; $display("FAIL stall_cmd[%0d]: got %0d expected %0d", k, cmd, counter_types::CmdNone); end
      n_checks++; if (done !== 1'b0) begin n_errors++; $display("FAIL stall_done_early[%0d]: got %b expected 0", k, done); end
    end
    tick; beat_ready = 1'b0; #1;
    n_checks++; if (done !== 1'b1 || beat_valid !== 1'b0) begin n_errors++; $display("FAIL stall_done: got done=%b valid=%b expected 1 0", done, beat_valid); end
    tick; #1;
    n_checks++; if (done !== 1'b0) begin n_errors++; $display("FAIL stall_done_clear: got %b expected 0", done); end
  endtask

  task automatic test_back_to_back;
    req_valid = 1'b1; req_addr = 11'h100; req_len = 8'd1; beat_ready = 1'b1;
    tick; req_addr = 11'h200; req_len = 8'd0; #1;
    n_checks++; if (req_ready !== 1'b0) begin n_errors++; $display("FAIL b2b_ready_busy: got %b expected 0", req_ready); end
    tick; #1;
    n_checks++; if (addr !== 11'h100) begin n_errors++; $display("FAIL b2b_beat0: got %h expected 100", addr); end
    tick; #1;
    n_checks++; if (addr !== 11'h101 || load_addr !== 11'h100) begin n_errors++; $display("FAIL b2b_beat1: got addr=%h load=%h expected 101 100", addr, load_addr); end
    tick; #1;
    n_checks++; if (done !== 1'b1 || req_ready !== 1'b1) begin n_errors++; $display("FAIL b2b_done: got done=%b ready=%b expected 1 1", done, req_ready); end
    tick; req_valid = 1'b0; #1;
    n_checks++; if (cmd !== counter_types::CmdLoad || load_addr !== 11'h200) begin n_errors++; $display("FAIL b2b_second_load: got cmd=%0d load=%h expected %0d 200", cmd, load_addr, counter_types::CmdLoad); end
    n_checks++; if (done !== 1'b0) begin n_errors++; $display("FAIL b2b_done_clear: got %b expected 0", done); end
    tick; #1;
    n_checks++; if (beat_valid !== 1'b1 || addr !== 11'h200) begin n_errors++; $display("FAIL b2b_second_beat: got valid=%b addr=%h expected 1 200", beat_valid, addr); end
    tick; #1;
    n_checks++; if (done !== 1'b1) begin n_errors++; $display("FAIL b2b_second_done: got %b expected 1", done); end
  endtask

  task automatic test_reset_mid;
    req_valid = 1'b1; req_addr = 11'h050; req_len = 8'd5; beat_ready = 1'b1;
    tick; req_valid = 1'b0;
    tick; tick; #1;
    n_checks++; if (addr !== 11'h051 || beat_valid !== 1'b1) begin n_errors++; $display("FAIL rstmid_pre: got addr=%h valid=%b expected 051 1", addr, beat_valid); end
    reset = 1'b0;
    tick; #1;
    n_checks++; if (cmd !== counter_types::CmdNone || beat_valid !== 1'b0 || req_ready !== 1'b1) begin n_errors++; $display("FAIL rstmid_idle: got cmd=%0d valid=%b ready=%b expected 0 0 1", cmd, beat_valid, req_ready); end
    n_checks++; if (done !== 1'b0 || addr !== 11'h000) begin n_errors++; $display("FAIL rstmid_state: got done=%b addr=%h expected 0 000", done, addr); end
    reset = 1'b1;
    tick; #1;
    n_checks++; if (done !== 1'b0 || beat_valid !== 1'b0) begin n_errors++; $display("FAIL rstmid_after: got done=%b valid=%b expected 0 0", done, beat_valid); end
  endtask

`ifdef BURST_SEQ_ABORT_EN
  task automatic test_abort;
    abort = 1'b1; #1;
    tick; abort = 1'b0; #1;
    n_checks++; if (aborted !== 1'b0) begin n_errors++; $display("FAIL abort_idle_ignored: got %b expected 0", aborted); end
    req_valid = 1'b1; req_addr = 11'h300; req_len = 8'd7; beat_ready = 1'b1;
    tick; req_valid = 1'b0;
    tick; tick; abort = 1'b1; #1;
    n_checks++; if (addr !== 11'h301 || cmd !== counter_types::CmdNone) begin n_errors++; $display("FAIL abort_cmd: got addr=%h cmd=%0d expected 301 0", addr, cmd); end
    tick; abort = 1'b0; #1;
    n_checks++; if (aborted !== 1'b1 || done !== 1'b0 || req_ready !== 1'b1) begin n_errors++; $display("FAIL abort_pulse: got aborted=%b done=%b ready=%b expected 1 0 1", aborted, done, req_ready); end
    tick; #1;
    n_checks++; if (aborted !== 1'b0 || done !== 1'b0) begin n_errors++; $display("FAIL abort_clear: got aborted=%b done=%b expected 0 0", aborted, done); end
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset;
    test_basic;
    test_wrap;
    test_stall;
    test_back_to_back;
    test_reset_mid;
`ifdef BURST_SEQ_ABORT_EN
    test_abort;
`endif
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
